hack_rom_boot_loader: RTL and testbench

- Parametrised successor to the fixed-length file-to-ROM loader plus the top-level boot glue that gates hack_external_reset.
- Pulls a program image of runtime-selectable length from a valid/ready word stream (flash reader, UART or test source) and pushes it word-by-word into the hack_soc ROM loader port.
- Holds the Hack CPU in reset until the image is loaded, then releases it.
- Adds a per-word handshake timeout, an error state, and re-boot on request.

---
 rtl/hack_soc_pkg.sv | 18 +
 rtl/hack_boot_timeout.sv | 33 +++
 rtl/hack_rom_boot_loader.sv | 154 +++++++++++++++
 tb/tb_hack_rom_boot_loader.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_soc_pkg.sv
// Purpose: shared types for the Hack SoC boot path (loader FSM states, word width).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hack_soc_pkg;

    localparam int INSTRUCTION_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        FETCH,
        LOAD,
        ACK,
        DONE,
        ERROR
    } boot_state_t;

endpackage

// File: rtl/hack_boot_timeout.sv
// Purpose: loadable down-counter with clear, enable and expired flag (reset hold and handshake timeout).
// Latency: load/clear take effect the next cycle; expired is combinational on the count.
// Backpressure: none; enable simply freezes the count.
//
// Ports: clk, reset (sync, active high), clear (count to 0), load/load_value,
//        enable (decrement while non-zero), expired (count == 0).
module hack_boot_timeout #(
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/hack_rom_boot_loader.sv
// Purpose: pulls a program image from a valid/ready source into the SoC ROM loader, gating the CPU reset.
// Latency: 3 cycles per word with a fast source and SoC (FETCH, LOAD, ACK).
// Backpressure: src_ready only in FETCH; LOAD/ACK wait on the SoC, bounded by TIMEOUT_CYCLES.
//
// Ports: clk, reset | start, image_len | src_valid/src_data/src_ready |
//        rom_loader_reset/load/data, rom_loader_load_received/ack |
//        hack_external_reset, busy, done, error, words_loaded.
module hack_rom_boot_loader
    import hack_soc_pkg::*;
#(
    parameter int DATA_WIDTH     = INSTRUCTION_WIDTH,
    parameter int COUNT_WIDTH    = 16,
    parameter int RESET_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] image_len,
    input  logic                   src_valid,
    input  logic [DATA_WIDTH-1:0]  src_data,
    output logic                   src_ready,
    output logic                   rom_loader_reset,
    output logic                   rom_loader_load,
    output logic [DATA_WIDTH-1:0]  rom_loader_data,
    input  logic                   rom_loader_load_received,
    input  logic                   rom_loader_ack,
    output logic                   hack_external_reset,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [COUNT_WIDTH-1:0] words_loaded
);

    // One counter serves both the reset hold and the per-word timeout.
    localparam int TMAX = (TIMEOUT_CYCLES > RESET_CYCLES) ? TIMEOUT_CYCLES : RESET_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    boot_state_t            state, state_nxt;
    logic [COUNT_WIDTH-1:0] len_q;
    logic [COUNT_WIDTH-1:0] words_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   hack_rst_q;

    logic                   take_start, word_taken, word_done;
    logic                   tmr_clear, tmr_load, tmr_en, tmr_expired;
    logic [TW-1:0]          tmr_value;
    logic                   timeout_hit;
    logic                   last_word;

    hack_boot_timeout #(.WIDTH(TW)) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .clear      (tmr_clear),
        .load       (tmr_load),
        .load_value (tmr_value),
        .enable     (tmr_en),
        .expired    (tmr_expired)
    );

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && tmr_expired;
    assign last_word   = ((words_q + COUNT_WIDTH'(1)) == len_q);

    always_comb begin
        state_nxt  = state;
        take_start = 1'b0;
        word_taken = 1'b0;
        word_done  = 1'b0;
        tmr_clear  = 1'b0;
        tmr_load   = 1'b0;
        tmr_en     = 1'b0;
        tmr_value  = '0;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    take_start = 1'b1;
                    if (image_len == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RST;
                        tmr_load  = 1'b1;
                        tmr_value = TW'(RESET_CYCLES - 1);
                    end
                end
            end
            RST: begin
                if (tmr_expired) state_nxt = FETCH;
                else             tmr_en    = 1'b1;
            end
            FETCH: begin
                if (src_valid) begin
                    word_taken = 1'b1;
                    state_nxt  = LOAD;
                    tmr_load   = 1'b1;
                    tmr_value  = TW'(TIMEOUT_CYCLES);
                end
            end
            LOAD: begin
                tmr_en = 1'b1;
                if (rom_loader_load_received) begin
                    // Ack coincident with load_received skips the ACK wait.
                    if (rom_loader_ack) word_done = 1'b1;
                    else                state_nxt = ACK;
                end else if (timeout_hit) begin
                    state_nxt = ERROR;
                end
            end
            ACK: begin
                tmr_en = 1'b1;
                if (rom_loader_ack)   word_done = 1'b1;
                else if (timeout_hit) state_nxt = ERROR;
            end
            default: state_nxt = IDLE;
        endcase
        if (word_done) begin
            state_nxt = last_word ? DONE : FETCH;
        end
        if ((state_nxt == DONE || state_nxt == ERROR) && !take_start) begin
            tmr_clear = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            len_q      <= '0;
            words_q    <= '0;
            data_q     <= '0;
            hack_rst_q <= 1'b1;
        end else begin
            state <= state_nxt;
            if (take_start) begin
                len_q   <= image_len;
                words_q <= '0;
            end else if (word_done) begin
                words_q <= words_q + COUNT_WIDTH'(1);
            end
            if (word_taken) data_q <= src_data;
            // CPU runs only once DONE has been reached and no re-boot is requested.
            hack_rst_q <= !((state == DONE) && !start);
        end
    end

    assign src_ready           = (state == FETCH);
    assign rom_loader_reset    = (state == RST);
    assign rom_loader_load     = (state == LOAD);
    assign rom_loader_data     = data_q;
    assign hack_external_reset = hack_rst_q;
    assign busy                = (state == RST) || (state == FETCH) || (state == LOAD) || (state == ACK);
    assign done                = (state == DONE);
    assign error               = (state == ERROR);
    assign words_loaded        = words_q;

endmodule

// File: tb/tb_hack_rom_boot_loader.sv
// Purpose: directed bench for hack_rom_boot_loader with a behavioural source and SoC loader port.
// Latency: expectations hand-computed (3 cycles/word fast path, error 17 cycles after LOAD entry at timeout 16).
// Backpressure: source valid and SoC handshake delays are varied per scenario.
module tb_hack_rom_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] image_len;
    logic        src_valid;
    logic [15:0] src_data;
    logic        src_ready;
    logic        rom_loader_reset;
    logic        rom_loader_load;
    logic [15:0] rom_loader_data;
    logic        rom_loader_load_received;
    logic        rom_loader_ack;
    logic        hack_external_reset;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    always #5 clk = ~clk;

    hack_rom_boot_loader #(
        .DATA_WIDTH(16), .COUNT_WIDTH(16), .RESET_CYCLES(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .image_len(image_len),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .rom_loader_reset(rom_loader_reset), .rom_loader_load(rom_loader_load),
        .rom_loader_data(rom_loader_data),
        .rom_loader_load_received(rom_loader_load_received), .rom_loader_ack(rom_loader_ack),
        .hack_external_reset(hack_external_reset), .busy(busy), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model / monitor state
    logic [15:0] src_base = 16'h0;
    int          src_idx = 0;
    logic [15:0] got_words [0:63];
    int n_written = 0, order_err = 0, viol = 0, falls = 0, load_rises = 0;
    int cur_run = 0, last_run = 0, rst_total = 0;
    int cyc = 0, load_cyc = 0, err_cyc = 0;
    int never_idx = -1;
    int lr_dly = 0, ack_dly = 0, lr_wait = 0, ack_wait = 0, phase = 0;
    bit rnd = 1'b0, ack_same = 1'b0;
    bit prev_hack = 1'b1, prev_err = 1'b0, prev_load = 1'b0;

    // Source, SoC and monitors all act on the falling edge.
    initial begin
        src_valid = 1'b0;
        src_data  = '0;
        rom_loader_load_received = 1'b0;
        rom_loader_ack = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rom_loader_load && rom_loader_reset) viol++;
            if (rom_loader_load && src_ready)        viol++;
            if (prev_hack && !hack_external_reset)   falls++;
            prev_hack = hack_external_reset;
            if (rom_loader_reset) begin
                cur_run++;
                rst_total++;
            end else if (cur_run != 0) begin
                last_run = cur_run;
                cur_run  = 0;
            end
            if (error && !prev_err) err_cyc = cyc;
            prev_err = error;
            if (rom_loader_load && !prev_load) begin
                load_rises++;
                if (n_written == never_idx) load_cyc = cyc;
            end
            prev_load = rom_loader_load;

            src_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            src_data  = src_base + 16'(src_idx);
            if (src_valid && src_ready) src_idx++;

            if (!busy) begin
                phase = 0; lr_wait = 0;
                rom_loader_load_received = 1'b0;
                rom_loader_ack = 1'b0;
            end else begin
                case (phase)
                    0: begin
                        rom_loader_ack = 1'b0;
                        if (rom_loader_load) begin
                            if (lr_wait >= lr_dly) begin
                                rom_loader_load_received = 1'b1;
                                if (n_written < 64) got_words[n_written] = rom_loader_data;
                                if (rom_loader_data != src_base + 16'(n_written)) order_err++;
                                n_written++;
                                if (n_written - 1 == never_idx) begin
                                    phase = 4;
                                end else if (ack_same) begin
                                    rom_loader_ack = 1'b1;
                                    phase = 3;
                                end else begin
                                    ack_wait = 0;
                                    phase = 1;
                                end
                            end else begin
                                lr_wait++;
                            end
                        end
                    end
                    1: begin
                        rom_loader_load_received = 1'b0;
                        if (ack_wait >= ack_dly) begin
                            rom_loader_ack = 1'b1;
                            phase = 3;
                        end else begin
                            ack_wait++;
                        end
                    end
                    3: begin
                        rom_loader_load_received = 1'b0;
                        rom_loader_ack = 1'b0;
                        lr_wait = 0;
                        phase = 0;
                        if (rnd) begin
                            ack_dly = $urandom_range(0, 7);
                            lr_dly  = $urandom_range(0, 2);
                        end
                    end
                    default: begin
                        rom_loader_load_received = 1'b0;
                        rom_loader_ack = 1'b0;
                    end
                endcase
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_stats(input logic [15:0] base);
        src_base = base; src_idx = 0; n_written = 0; order_err = 0; viol = 0;
        falls = 0; load_rises = 0; last_run = 0; rst_total = 0;
    endtask

    task automatic start_load(input logic [15:0] len);
        image_len = len;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (!(done || error) && n < budget) begin
            step();
            n++;
        end
        check_eq("wait_end", 32'(done | error), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; image_len = '0;
        repeat (3) step();
        check_eq("rst_hack", 32'(hack_external_reset), 32'd1);
        check_eq("rst_outs", 32'({rom_loader_load, rom_loader_reset, src_ready, busy, done, error}), 32'd0);
        check_eq("rst_words", 32'(words_loaded), 32'd0);
        check_eq("rst_data", 32'(rom_loader_data), 32'd0);
        reset = 1'b0;
        step();

        // Nominal: 24 words, SoC answers one cycle after load.
        clear_stats(16'h1000); lr_dly = 1; ack_dly = 0;
        start_load(16'd24);
        check_eq("nom_busy", 32'(busy), 32'd1);
        wait_end(600);
        check_eq("nom_done", 32'(done), 32'd1);
        check_eq("nom_hack_entry", 32'(hack_external_reset), 32'd1);
        step();
        check_eq("nom_hack_fall", 32'(hack_external_reset), 32'd0);
        step();
        check_eq("nom_words", 32'(words_loaded), 32'd24);
        check_eq("nom_written", 32'(n_written), 32'd24);
        check_eq("nom_pulses", 32'(load_rises), 32'd24);
        check_eq("nom_order", 32'(order_err), 32'd0);
        check_eq("nom_falls", 32'(falls), 32'd1);
        check_eq("nom_rst_run", 32'(last_run), 32'd4);
        check_eq("nom_excl", 32'(viol), 32'd0);

        // Re-boot from DONE, ack coincident with load_received.
        clear_stats(16'h2000); lr_dly = 0; ack_same = 1'b1;
        start_load(16'd24);
        check_eq("reboot_hack", 32'(hack_external_reset), 32'd1);
        check_eq("reboot_done_clr", 32'(done), 32'd0);
        wait_end(600);
        step();
        check_eq("reboot_words", 32'(words_loaded), 32'd24);
        check_eq("reboot_order", 32'(order_err), 32'd0);
        check_eq("reboot_written", 32'(n_written), 32'd24);
        ack_same = 1'b0;

        // Back-pressure: random valid and SoC delays.
        clear_stats(16'hA000); rnd = 1'b1;
        start_load(16'd5);
        wait_end(600);
        step();
        check_eq("bp_done", 32'(done), 32'd1);
        check_eq("bp_written", 32'(n_written), 32'd5);
        for (int i = 0; i < 5; i++) check_eq("bp_word", 32'(got_words[i]), 32'hA000 + 32'(i));
        check_eq("bp_excl", 32'(viol), 32'd0);
        rnd = 1'b0; lr_dly = 0; ack_dly = 0;

        // Zero length from IDLE.
        reset = 1'b1; step(); reset = 1'b0; step();
        clear_stats(16'h0);
        start_load(16'd0);
        check_eq("zero_done", 32'(done), 32'd1);
        check_eq("zero_busy", 32'(busy), 32'd0);
        repeat (3) step();
        check_eq("zero_no_rst", 32'(rst_total), 32'd0);
        check_eq("zero_words", 32'(words_loaded), 32'd0);

        // Timeout: third word never acknowledged.
        clear_stats(16'h3000); never_idx = 2;
        start_load(16'd5);
        wait_end(600);
        step();
        check_eq("to_error", 32'(error), 32'd1);
        check_eq("to_done", 32'(done), 32'd0);
        check_eq("to_words", 32'(words_loaded), 32'd2);
        check_eq("to_hack", 32'(hack_external_reset), 32'd1);
        check_eq("to_busy", 32'(busy), 32'd0);
        check_eq("to_latency", 32'(err_cyc - load_cyc), 32'd17);
        never_idx = -1;

        // Reset during word 10 of 24, then a full reload.
        clear_stats(16'h4000); lr_dly = 1;
        start_load(16'd24);
        check_eq("mid_err_clr", 32'(error), 32'd0);
        begin
            int n = 0;
            while (n_written < 10 && n < 600) begin step(); n++; end
            check_eq("mid_reach10", 32'(n_written), 32'd10);
        end
        reset = 1'b1;
        step();
        check_eq("mid_rst_hack", 32'(hack_external_reset), 32'd1);
        check_eq("mid_rst_outs", 32'({rom_loader_load, rom_loader_reset, src_ready, busy, done, error}), 32'd0);
        check_eq("mid_rst_words", 32'(words_loaded), 32'd0);
        check_eq("mid_rst_data", 32'(rom_loader_data), 32'd0);
        step();
        reset = 1'b0;
        clear_stats(16'h5000);
        step();
        start_load(16'd24);
        wait_end(600);
        step();
        check_eq("mid_rst_run", 32'(last_run), 32'd4);
        check_eq("mid_words", 32'(words_loaded), 32'd24);
        check_eq("mid_written", 32'(n_written), 32'd24);
        check_eq("mid_order", 32'(order_err), 32'd0);
        check_eq("mid_done", 32'(done), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
